rf_writeback: RTL and testbench

RF_WRITEBACK -- requirements
Module: rf_writeback

---
 rtl/rf_wb_pkg.sv | 34 +++
 rtl/rf_wb_fifo.sv | 86 ++++++++
 rtl/rf_writeback.sv | 120 ++++++++++++
 tb/tb_rf_writeback.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file writeback block.
// Load extension helper is used only when RF_WB_LOAD_EXT_EN is defined.
package rf_wb_pkg;

  localparam int XLEN     = 32;
  localparam int WB_DEPTH = 4;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  function automatic logic [XLEN-1:0] load_ext(
    input logic [2:0]      f3,
    input logic [1:0]      lo,
    input logic [XLEN-1:0] d
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [XLEN-1:0] r;
    b = d[{lo, 3'b000} +: 8];
    h = lo[1] ? d[31:16] : d[15:0];
    case (f3)
      F3_LB:   r = {{24{b[7]}}, b};
      F3_LH:   r = {{16{h[15]}}, h};
      F3_LBU:  r = {24'd0, b};
      F3_LHU:  r = {16'd0, h};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Load-result buffer: storage, pointers, occupancy, kill bits and
// rd-match lookup for the decode-stage hazard query.
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   push_i,
  input  logic [4:0]             push_rd_i,
  input  logic [XLEN-1:0]        push_data_i,
  input  logic                   pop_i,
  input  logic                   kill_en_i,
  input  logic [4:0]             kill_rd_i,
  input  logic [4:0]             rd1_i,
  input  logic [4:0]             rd2_i,
  output logic [4:0]             head_rd_o,
  output logic [XLEN-1:0]        head_data_o,
  output logic                   head_kill_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   match1_o,
  output logic                   match2_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]      rd_q   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] kill_q;
  logic [AW-1:0]   wp_q;
  logic [AW-1:0]   rp_q;
  logic [CW-1:0]   cnt_q;
  logic            kill_act;

  assign kill_act = kill_en_i && (kill_rd_i != 5'd0);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
      kill_q <= '0;
    end else begin
      // A younger ALU write makes older queued loads to the same rd dead
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_act && vld_q[i] && rd_q[i] == kill_rd_i)
          kill_q[i] <= 1'b1;
      end
      if (pop_i) begin
        vld_q[rp_q] <= 1'b0;
        rp_q        <= rp_q + AW'(1);
      end
      if (push_i) begin
        vld_q[wp_q]  <= 1'b1;
        kill_q[wp_q] <= kill_act && (push_rd_i == kill_rd_i);
        rd_q[wp_q]   <= push_rd_i;
        data_q[wp_q] <= push_data_i;
        wp_q         <= wp_q + AW'(1);
      end
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_comb begin
    match1_o = 1'b0;
    match2_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && !kill_q[i]) begin
        if (rd_q[i] == rd1_i) match1_o = 1'b1;
        if (rd_q[i] == rd2_i) match2_o = 1'b1;
      end
    end
  end

  assign head_rd_o   = rd_q[rp_q];
  assign head_data_o = data_q[rp_q];
  assign head_kill_o = kill_q[rp_q];
  assign count_o     = cnt_q;
  assign full_o      = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/rf_writeback.sv
// Register-file writeback arbiter: ALU results win, loads queue behind.
// Define RF_WB_LOAD_EXT_EN to extract/extend sub-word loads at enqueue.
module rf_writeback
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   alu_valid,
  input  logic [4:0]             alu_rd,
  input  logic [XLEN-1:0]        alu_data,
  input  logic                   mem_valid,
  input  logic [4:0]             mem_rd,
  input  logic [XLEN-1:0]        mem_data,
  input  logic [2:0]             mem_funct3,
  input  logic [1:0]             mem_addr_lo,
  output logic                   mem_ready,
  output logic                   regWen,
  output logic [4:0]             writeReg,
  output logic [XLEN-1:0]        writeData,
  input  logic [4:0]             read1,
  input  logic [4:0]             read2,
  output logic                   pend1,
  output logic                   pend2,
  output logic [$clog2(DEPTH):0] wb_count
);

  logic            push;
  logic            pop;
  logic            full;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;
  logic            head_kill;
  logic [XLEN-1:0] push_data;
  logic            m1;
  logic            m2;

  logic            wen_q;
  logic            wen_d;
  logic [4:0]      wreg_q;
  logic [4:0]      wreg_d;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] wdata_d;

`ifdef RF_WB_LOAD_EXT_EN
  assign push_data = load_ext(mem_funct3, mem_addr_lo, mem_data);
`else
  logic unused_ext;
  assign unused_ext = ^{mem_funct3, mem_addr_lo};
  assign push_data  = mem_data;
`endif

  assign mem_ready = !full;
  assign push      = mem_valid && !full;
  assign pop       = !alu_valid && (wb_count != '0);

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clk         (Clk),
    .Rst         (Rst),
    .push_i      (push),
    .push_rd_i   (mem_rd),
    .push_data_i (push_data),
    .pop_i       (pop),
    .kill_en_i   (alu_valid),
    .kill_rd_i   (alu_rd),
    .rd1_i       (read1),
    .rd2_i       (read2),
    .head_rd_o   (head_rd),
    .head_data_o (head_data),
    .head_kill_o (head_kill),
    .count_o     (wb_count),
    .full_o      (full),
    .match1_o    (m1),
    .match2_o    (m2)
  );

  always_comb begin
    wen_d   = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    unique case (1'b1)
      alu_valid: begin
        if (alu_rd != 5'd0) begin
          wen_d   = 1'b1;
          wreg_d  = alu_rd;
          wdata_d = alu_data;
        end
      end
      pop: begin
        if (!head_kill && head_rd != 5'd0) begin
          wen_d   = 1'b1;
          wreg_d  = head_rd;
          wdata_d = head_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      wen_q   <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
    end else begin
      wen_q   <= wen_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
    end
  end

  assign regWen    = wen_q;
  assign writeReg  = wreg_q;
  assign writeData = wdata_q;

  assign pend1 = (read1 != 5'd0) && (m1 || (wen_q && wreg_q == read1));
  assign pend2 = (read2 != 5'd0) && (m2 || (wen_q && wreg_q == read2));

endmodule

// File: tb/tb_rf_writeback.sv
// Randomized and directed bench for rf_writeback against a queue model.
// Sub-word load checks compile in when RF_WB_LOAD_EXT_EN is defined.
module tb_rf_writeback;

  localparam int DEPTH = 4;

  logic        Clk;
  logic        Rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic [2:0]  mem_funct3;
  logic [1:0]  mem_addr_lo;
  logic        mem_ready;
  logic        regWen;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [4:0]  read1;
  logic [4:0]  read2;
  logic        pend1;
  logic        pend2;
  logic [$clog2(DEPTH):0] wb_count;

  rf_writeback #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo),
    .mem_ready(mem_ready),
    .regWen(regWen), .writeReg(writeReg), .writeData(writeData),
    .read1(read1), .read2(read2), .pend1(pend1), .pend2(pend2),
    .wb_count(wb_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          killed;
  } ent_t;

  ent_t        mq[$];
  bit          m_wen;
  logic [4:0]  m_reg;
  logic [31:0] m_data;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ext(input logic [2:0] f3,
                                      input logic [1:0] lo,
                                      input logic [31:0] d);
`ifdef RF_WB_LOAD_EXT_EN
    logic [31:0] s;
    logic [31:0] h;
    s = d >> (8 * lo);
    h = d >> (16 * lo[1]);
    case (f3)
      3'd0:    return 32'($signed(s[7:0]));
      3'd1:    return 32'($signed(h[15:0]));
      3'd4:    return s & 32'hFF;
      3'd5:    return h & 32'hFFFF;
      default: return d;
    endcase
`else
    return d + 32'(f3 & 3'd0) + 32'(lo & 2'd0);
`endif
  endfunction

  function automatic bit exp_pend(input logic [4:0] r);
    if (r == 0) return 0;
    if (m_wen && m_reg == r) return 1;
    foreach (mq[i]) if (!mq[i].killed && mq[i].rd == r) return 1;
    return 0;
  endfunction

  task automatic step(input bit rstn,
                      input bit av, input logic [4:0] ard,
                      input logic [31:0] ad,
                      input bit mv, input logic [4:0] mrd,
                      input logic [31:0] md,
                      input logic [2:0] f3, input logic [1:0] alo);
    bit   acc;
    ent_t e;
    Rst = rstn; alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    mem_funct3 = f3; mem_addr_lo = alo;
    #1;
    check("mem_ready", 32'(mem_ready), 32'(mq.size() < DEPTH));
    check("count_pre", 32'(wb_count), 32'(mq.size()));
    check("pend1", 32'(pend1), 32'(exp_pend(read1)));
    check("pend2", 32'(pend2), 32'(exp_pend(read2)));
    @(posedge Clk);
    if (!rstn) begin
      mq.delete();
      m_wen = 0; m_reg = 0; m_data = 0;
    end else begin
      acc = mv && (mq.size() < DEPTH);
      if (av) begin
        foreach (mq[i]) if (ard != 0 && mq[i].rd == ard) mq[i].killed = 1;
        m_wen = (ard != 0);
        if (m_wen) begin m_reg = ard; m_data = ad; end
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_wen = !e.killed && e.rd != 0;
        if (m_wen) begin m_reg = e.rd; m_data = e.data; end
      end else begin
        m_wen = 0;
      end
      if (acc) begin
        e.rd = mrd;
        e.data = ext(f3, alo, md);
        e.killed = av && ard != 0 && ard == mrd;
        mq.push_back(e);
      end
    end
    @(negedge Clk);
    check("regWen", 32'(regWen), 32'(m_wen));
    check("writeReg", 32'(writeReg), 32'(m_reg));
    check("writeData", writeData, m_data);
    check("count", 32'(wb_count), 32'(mq.size()));
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 3'd2, 0);
  endtask

  logic [2:0] f3tab [5];

  initial begin
    f3tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    Rst = 0; alu_valid = 1; alu_rd = 4; alu_data = 1;
    mem_valid = 1; mem_rd = 4; mem_data = 2;
    mem_funct3 = 3'd2; mem_addr_lo = 0; read1 = 0; read2 = 0;
    m_wen = 0; m_reg = 0; m_data = 0;
    @(posedge Clk);
    @(negedge Clk);
    check("rst_regWen", 32'(regWen), 0);
    check("rst_writeData", writeData, 0);
    check("rst_count", 32'(wb_count), 0);
    check("rst_ready", 32'(mem_ready), 1);

    // ALU only
    step(1, 1, 5, 32'h1234, 0, 0, 0, 3'd2, 0);
    check("alu_wen", 32'(regWen), 1);
    check("alu_reg", 32'(writeReg), 5);
    check("alu_data", writeData, 32'h1234);

    // ALU and load collide
    step(1, 1, 3, 32'h33, 1, 7, 32'h77, 3'd2, 0);
    check("col_first", 32'(writeReg), 3);
    idle();
    check("col_second", 32'(writeReg), 7);
    check("col_data", writeData, 32'h77);

    // fill with ALU busy, one extra load dropped
    for (int i = 0; i <= DEPTH; i++)
      step(1, 1, 1, 32'(i), 1, 5'(10 + i), 32'(100 + i), 3'd2, 0);
    check("full_count", 32'(wb_count), DEPTH);
    check("full_ready", 32'(mem_ready), 0);
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      check("drain_order", 32'(writeReg), 32'(10 + i));
    end
    check("drain_empty", 32'(wb_count), 0);

    // kill older load by younger ALU write
    read1 = 9;
    step(1, 1, 1, 32'h1, 1, 9, 32'h99, 3'd2, 0);
    check("kill_pend_q", 32'(pend1), 1);
    step(1, 1, 9, 32'hA, 0, 0, 0, 3'd2, 0);
    check("kill_alu", writeData, 32'hA);
    idle();
    check("kill_pop_wen", 32'(regWen), 0);
    idle();
    check("kill_pend_clr", 32'(pend1), 0);
    read1 = 0;

`ifdef RF_WB_LOAD_EXT_EN
    step(1, 0, 0, 0, 1, 12, 32'h0080_0000, 3'd0, 2'd2);
    idle();
    check("ext_lb", writeData, 32'hFFFF_FF80);
    step(1, 0, 0, 0, 1, 12, 32'h0080_0000, 3'd4, 2'd2);
    idle();
    check("ext_lbu", writeData, 32'h0000_0080);
`endif

    // reset with queued loads
    for (int i = 0; i < 3; i++)
      step(1, 1, 2, 0, 1, 5'(20 + i), 32'(i), 3'd2, 0);
    check("pre_rst_count", 32'(wb_count), 3);
    step(0, 1, 6, 32'h66, 1, 6, 32'h6, 3'd2, 0);
    check("rst_mid_count", 32'(wb_count), 0);
    check("rst_mid_wen", 32'(regWen), 0);
    for (int i = 0; i < 3; i++) begin
      idle();
      check("rst_no_write", 32'(regWen), 0);
    end

    for (int n = 0; n < 600; n++) begin
      logic [2:0] f3;
`ifdef RF_WB_LOAD_EXT_EN
      f3 = f3tab[$urandom_range(0, 4)];
`else
      f3 = 3'($urandom);
`endif
      read1 = 5'($urandom_range(0, 7));
      read2 = 5'($urandom_range(0, 7));
      step($urandom_range(0, 59) != 0,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
           f3, 2'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
